// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode classification for the
// sequential ALU and its iterative multiply/divide unit.
package alu_pkg;

  localparam logic [4:0] OP_ADDU = 5'b00000;
  localparam logic [4:0] OP_SUBU = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_NOR  = 5'b00111;
  localparam logic [4:0] OP_LUI  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01010;
  localparam logic [4:0] OP_SLT  = 5'b01011;
  localparam logic [4:0] OP_SRA  = 5'b01100;
  localparam logic [4:0] OP_SRL  = 5'b01101;
  localparam logic [4:0] OP_SLL  = 5'b01110;
  localparam logic [4:0] OP_MULU = 5'b10000;
  localparam logic [4:0] OP_MUL  = 5'b10001;
  localparam logic [4:0] OP_DIVU = 5'b10010;
  localparam logic [4:0] OP_DIV  = 5'b10011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Only 100xx runs through the iterative unit; 101xx/11xxx are illegal.
  function automatic logic is_multicycle(input logic [4:0] op);
    return op[4] && (op[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes,
// with sign correction applied combinationally once the count reaches zero.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo, mc, a_q;
  logic               div_q, negq_q, negr_q, dz_q, ovf_q;
  logic [WIDTH-1:0]   amag, bmag;
  logic [WIDTH-1:0]   nhi, nlo;
  logic [WIDTH:0]     madd, rext, rsub;
  logic               ge;
  logic [2*WIDTH-1:0] prod;

  assign amag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign bmag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(WIDTH);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // done marks the cycle of the final step; results are ready the cycle after.
  assign done = (cnt == CW'(1));

  // mul: lo = multiplier, mc = multiplicand; div: lo = dividend, mc = divisor
  always_ff @(posedge clk) begin
    if (start) begin
      hi     <= '0;
      lo     <= is_div ? amag : bmag;
      mc     <= is_div ? bmag : amag;
      a_q    <= a;
      div_q  <= is_div;
      negq_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      negr_q <= is_signed && a[WIDTH-1];
      dz_q   <= is_div && (b == '0);
      ovf_q  <= is_div && is_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    end else if (cnt != '0) begin
      hi <= nhi;
      lo <= nlo;
    end
  end

  assign madd = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
  assign rext = {hi, lo[WIDTH-1]};
  assign rsub = rext - {1'b0, mc};
  assign ge   = (rext >= {1'b0, mc});

  always_comb begin
    if (div_q) begin
      nhi = ge ? rsub[WIDTH-1:0] : rext[WIDTH-1:0];
      nlo = {lo[WIDTH-2:0], ge};
    end else begin
      nhi = madd[WIDTH:1];
      nlo = {madd[0], lo[WIDTH-1:1]};
    end
  end

  assign prod = negq_q ? (~{hi, lo} + 1'b1) : {hi, lo};

  // Divide-by-zero bypasses sign correction: all-ones quotient, dividend as remainder.
  always_comb begin
    res_lo = prod[WIDTH-1:0];
    res_hi = prod[2*WIDTH-1:WIDTH];
    if (div_q) begin
      if (dz_q) begin
        res_lo = '1;
        res_hi = a_q;
      end else begin
        res_lo = negq_q ? (~lo + 1'b1) : lo;
        res_hi = negr_q ? (~hi + 1'b1) : hi;
      end
    end
  end

  assign ovf = ovf_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ALU ops in one cycle, iterative
// mul/div in WIDTH+2 cycles, results and flags held until consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_t state, state_nx;

  logic                    accept, mc_op, md_start, md_done, md_ovf;
  logic [WIDTH-1:0]        md_lo, md_hi;
  logic signed [WIDTH-1:0] as_p0, bs_p0;
  logic [SHW-1:0]          shamt_p0;
  logic [WIDTH:0]          sum_p0, dif_p0, srl_p0, sll_p0;
  logic signed [WIDTH:0]   sra_p0;
  logic                    ltu_p0, lts_p0;
  logic [WIDTH-1:0]        r_p0;
  logic                    carry_p0, ovf_p0, ill_p0;

  assign mc_op  = is_multicycle(op);
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    md_start  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) state_nx = mc_op ? BUSY : HOLD;
      end
      BUSY: if (md_done) state_nx = FIX;
      FIX:  state_nx = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = rst_n && out_ready;
        if (out_ready) state_nx = in_valid ? (mc_op ? BUSY : HOLD) : IDLE;
      end
      default: state_nx = IDLE;
    endcase
    md_start = in_valid && in_ready && mc_op;
  end

  // Single-cycle stage: combinational ALU on the live operands
  assign as_p0    = a;
  assign bs_p0    = b;
  assign shamt_p0 = a[SHW-1:0];
  assign sum_p0   = {1'b0, a} + {1'b0, b};
  assign dif_p0   = {1'b0, a} - {1'b0, b};
  assign ltu_p0   = dif_p0[WIDTH];
  assign lts_p0   = as_p0 < bs_p0;
  // Extra LSB/MSB catches the last bit shifted out; it stays 0 when shamt is 0.
  assign sra_p0   = $signed({b, 1'b0}) >>> shamt_p0;
  assign srl_p0   = {b, 1'b0} >> shamt_p0;
  assign sll_p0   = {1'b0, b} << shamt_p0;

  always_comb begin
    r_p0     = '0;
    carry_p0 = 1'b0;
    ovf_p0   = 1'b0;
    ill_p0   = 1'b0;
    if (op[4]) begin
      ill_p0 = 1'b1;
    end else begin
      case (op[3:0])
        4'b0000: begin r_p0 = sum_p0[WIDTH-1:0]; carry_p0 = sum_p0[WIDTH]; end
        4'b0010: begin
          r_p0   = sum_p0[WIDTH-1:0];
          ovf_p0 = (a[WIDTH-1] == b[WIDTH-1]) && (sum_p0[WIDTH-1] != a[WIDTH-1]);
        end
        4'b0001: begin r_p0 = dif_p0[WIDTH-1:0]; carry_p0 = ltu_p0; end
        4'b0011: begin
          r_p0   = dif_p0[WIDTH-1:0];
          ovf_p0 = (a[WIDTH-1] != b[WIDTH-1]) && (dif_p0[WIDTH-1] != a[WIDTH-1]);
        end
        4'b0100: r_p0 = a & b;
        4'b0101: r_p0 = a | b;
        4'b0110: r_p0 = a ^ b;
        4'b0111: r_p0 = ~(a | b);
        4'b1000, 4'b1001: r_p0 = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
        4'b1010: begin r_p0 = {{(WIDTH-1){1'b0}}, ltu_p0}; carry_p0 = ltu_p0; end
        4'b1011: r_p0 = {{(WIDTH-1){1'b0}}, lts_p0};
        4'b1100: begin r_p0 = sra_p0[WIDTH:1]; carry_p0 = sra_p0[0]; end
        4'b1101: begin r_p0 = srl_p0[WIDTH:1]; carry_p0 = srl_p0[0]; end
        default: begin r_p0 = sll_p0[WIDTH-1:0]; carry_p0 = sll_p0[WIDTH]; end
      endcase
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (md_start),
    .is_signed (op[0]),
    .is_div    (op[1]),
    .a         (a),
    .b         (b),
    .done      (md_done),
    .res_lo    (md_lo),
    .res_hi    (md_hi),
    .ovf       (md_ovf)
  );

  // Output stage: loaded on single-cycle acceptance or on the FIX cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r        <= '0;
      r_hi     <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept && !mc_op) begin
      r        <= r_p0;
      r_hi     <= '0;
      zero     <= (r_p0 == '0);
      carry    <= carry_p0;
      negative <= r_p0[WIDTH-1];
      overflow <= ovf_p0;
      illegal  <= ill_p0;
    end else if (state == FIX) begin
      r        <= md_lo;
      r_hi     <= md_hi;
      zero     <= (md_lo == '0);
      carry    <= 1'b0;
      negative <= md_lo[WIDTH-1];
      overflow <= md_ovf;
      illegal  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 and WIDTH=16 with hand-computed vectors.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  op = 5'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, zero, carry, negative, overflow, illegal;
  logic [31:0] r, r_hi;

  logic        iv16 = 1'b0;
  logic [4:0]  op16 = 5'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ir16, ov16, z16, c16, n16, o16, il16;
  logic [15:0] r16, rh16;

  int checks = 0;
  int passed = 0;
  int lat;
  logic seen;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .r(r), .r_hi(r_hi),
    .zero(zero), .carry(carry), .negative(negative), .overflow(overflow), .illegal(illegal)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(1'b1), .r(r16), .r_hi(rh16),
    .zero(z16), .carry(c16), .negative(n16), .overflow(o16), .illegal(il16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present an op in IDLE, scramble inputs after acceptance, count cycles to out_valid.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int l);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; op = OP_AND;
    l = 1;
    while (!out_valid && l < 200) begin @(posedge clk); #1; l++; end
  endtask

  task automatic issue16(input logic [4:0] o, input logic [15:0] x, input logic [15:0] y,
                         output int l);
    op16 = o; a16 = x; b16 = y; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = 16'h5A5A; b16 = 16'hA5A5;
    l = 1;
    while (!ov16 && l < 200) begin @(posedge clk); #1; l++; end
  endtask

  task automatic retire;
    @(posedge clk); #1;
  endtask

  function automatic logic [4:0] flags();
    return {carry, overflow, negative, zero, illegal};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {out_valid, r, r_hi}, '0);
    chk("rst_flags", flags(), 5'b00000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b1);

    issue(OP_ADD, 32'h7FFFFFFF, 32'h00000001, lat);
    chk("add_lat", lat, 1);
    chk("add_r", {r_hi, r}, 64'h00000000_80000000);
    chk("add_flags", flags(), 5'b01100);
    retire();

    issue(OP_ADDU, 32'h7FFFFFFF, 32'h00000001, lat);
    chk("addu_r", r, 32'h80000000);
    chk("addu_flags", flags(), 5'b00100);
    retire();

    issue(OP_SUBU, 32'h00000001, 32'h00000002, lat);
    chk("subu_r", r, 32'hFFFFFFFF);
    chk("subu_flags", flags(), 5'b10100);
    retire();

    issue(OP_SRA, 32'h00000008, 32'h80000000, lat);
    chk("sra_r", r, 32'hFF800000);
    chk("sra_flags", flags(), 5'b00100);
    retire();

    issue(OP_SLL, 32'h00000004, 32'hF0000001, lat);
    chk("sll_r", r, 32'h00000010);
    chk("sll_flags", flags(), 5'b10000);
    retire();

    issue(OP_SLT, 32'hFFFFFFFF, 32'h00000001, lat);
    chk("slt_r", r, 32'h00000001);
    retire();
    issue(OP_SLTU, 32'hFFFFFFFF, 32'h00000001, lat);
    chk("sltu_r", r, 32'h00000000);
    chk("sltu_flags", flags(), 5'b00010);
    retire();

    issue(OP_LUI, 32'h0, 32'h1234ABCD, lat);
    chk("lui_r", r, 32'hABCD0000);
    retire();

    issue(OP_MUL, 32'hFFFFFFFD, 32'h00000005, lat);
    chk("mul_lat", lat, 34);
    chk("mul_r", {r_hi, r}, 64'hFFFFFFFF_FFFFFFF1);
    chk("mul_flags", flags(), 5'b00100);
    retire();

    issue(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("mulu_r", {r_hi, r}, 64'hFFFFFFFE_00000001);
    chk("mulu_flags", flags(), 5'b00000);
    retire();

    issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002, lat);
    chk("div_lat", lat, 34);
    chk("div_r", {r_hi, r}, 64'hFFFFFFFF_FFFFFFFD);
    retire();

    issue(OP_DIVU, 32'h00001234, 32'h00000000, lat);
    chk("divz_lat", lat, 34);
    chk("divz_r", {r_hi, r}, 64'h00001234_FFFFFFFF);
    chk("divz_flags", flags(), 5'b00100);
    retire();

    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
    chk("divovf_r", {r_hi, r}, 64'h00000000_80000000);
    chk("divovf_flags", flags(), 5'b01100);
    retire();

    issue(5'b10101, 32'h12345678, 32'h9ABCDEF0, lat);
    chk("ill_lat", lat, 1);
    chk("ill_r", {r_hi, r}, '0);
    chk("ill_flags", flags(), 5'b00011);
    retire();

    out_ready = 1'b0;
    issue(OP_ADD, 32'd5, 32'd3, lat);
    chk("bp_first", {out_valid, r}, {1'b1, 32'd8});
    op = OP_SUB; a = 32'd10; b = 32'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, in_ready, r}, {1'b1, 1'b0, 32'd8});
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_b2b", {out_valid, r}, {1'b1, 32'd7});
    retire();

    op = OP_MUL; a = 32'h00001111; b = 32'h00002222; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstbusy_outs", {out_valid, r, r_hi}, '0);
    chk("rstbusy_flags", flags(), 5'b00000);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rstbusy_no_valid", seen, 1'b0);
    chk("rstbusy_ready", in_ready, 1'b1);
    issue(OP_ADDU, 32'd2, 32'd3, lat);
    chk("rstbusy_next", {lat[7:0], r}, {8'd1, 32'd5});
    retire();

    issue16(OP_ADD, 16'h7FFF, 16'h0001, lat);
    chk("w16_add", {lat[7:0], rh16, r16, o16}, {8'd1, 16'h0000, 16'h8000, 1'b1});
    retire();
    issue16(OP_MUL, 16'hFFFD, 16'h0005, lat);
    chk("w16_mul", {lat[7:0], rh16, r16}, {8'd18, 16'hFFFF, 16'hFFF1});
    retire();
    issue16(OP_DIV, 16'hFFF9, 16'h0002, lat);
    chk("w16_div", {lat[7:0], rh16, r16}, {8'd18, 16'hFFFF, 16'hFFFD});
    retire();
    issue16(OP_DIV, 16'h8000, 16'hFFFF, lat);
    chk("w16_divovf", {rh16, r16, o16}, {16'h0000, 16'h8000, 1'b1});
    retire();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
